// File: rtl/led_pkg.sv
// Shared definitions for the LED serial receiver slice.
//   LED_WIDTH_DEFAULT : default frame / parallel word width
//   ERR_CNT_W         : width of the optional rejected-frame counter
//   rx_state_e        : receiver FSM state
//   cnt_width()       : bit-counter width able to hold WIDTH+1
package led_pkg;

  localparam int unsigned LED_WIDTH_DEFAULT = 16;
  localparam int unsigned ERR_CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE,   // no bits held
    SHIFT,  // 1..WIDTH bits held
    OVER    // more than WIDTH bits seen
  } rx_state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/led_serial_rx_if.sv
// Bus between the LED serializer side and the receiver.
//   serial_in : serial data bit (valid while latch is high)
//   latch     : active-low commit strobe
//   led_out   : last accepted parallel pattern
//   out_valid : one-cycle pulse when led_out updates
//   frame_err : one-cycle pulse when a frame is rejected
//   busy      : a frame is partially received
//   err_count : rejected-frame count (only when LED_RX_ERR_CNT_EN is defined)
// modport master: drives serial_in/latch; modport slave: the receiver.
interface led_serial_rx_if
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = LED_WIDTH_DEFAULT
);

  logic             serial_in;
  logic             latch;
  logic [WIDTH-1:0] led_out;
  logic             out_valid;
  logic             frame_err;
  logic             busy;
`ifdef LED_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`endif

  modport master (
    output serial_in,
    output latch,
    input  led_out,
    input  out_valid,
    input  frame_err,
`ifdef LED_RX_ERR_CNT_EN
    input  err_count,
`endif
    input  busy
  );

  modport slave (
    input  serial_in,
    input  latch,
    output led_out,
    output out_valid,
    output frame_err,
`ifdef LED_RX_ERR_CNT_EN
    output err_count,
`endif
    output busy
  );

endinterface

// File: rtl/led_rx_shifter.sv
// MSB-first shift register with saturating bit counter.
//   clk, rst_n : clock, async active-low reset
//   shift_en   : accept bit_in this cycle
//   clr        : discard held bits (priority over shift_en)
//   bit_in     : serial bit
//   data       : shift register contents (first bit ends up at MSB)
//   count      : bits seen, saturating at WIDTH+1
// Once WIDTH bits are held the register freezes; only the counter advances.
module led_rx_shifter
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = LED_WIDTH_DEFAULT,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] SAT  = CW'(WIDTH + 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (clr) begin
      shift_d = '0;
      count_d = '0;
    end else if (shift_en) begin
      if (count_q < FULL) shift_d = {shift_q[WIDTH-2:0], bit_in};
      if (count_q != SAT) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  assign data  = shift_q;
  assign count = count_q;

endmodule

// File: rtl/led_serial_rx.sv
// LED serial receiver: rebuilds the parallel LED word from the serial
// stream and commits it on a low latch sample only if exactly WIDTH bits
// were received; otherwise the frame is rejected and led_out is kept.
//   clk, rst_n : clock, async active-low reset
//   bus        : led_serial_rx_if.slave (serial_in, latch, led_out,
//                out_valid, frame_err, busy, err_count)
// Optional feature macro: LED_RX_ERR_CNT_EN adds the saturating 8-bit
// rejected-frame counter on bus.err_count.
module led_serial_rx
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = LED_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  led_serial_rx_if.slave  bus
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  rx_state_e state_q, state_d;

  logic [WIDTH-1:0] shift_data;
  logic [CW-1:0]    bit_count;
  logic             shift_en;
  logic             clr;
  logic             commit_ok;
  logic             reject;

  logic [WIDTH-1:0] led_out_q, led_out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  led_rx_shifter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clr      (clr),
    .bit_in   (bus.serial_in),
    .data     (shift_data),
    .count    (bit_count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; bit_count is the count before the current bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.latch) state_d = SHIFT;
      SHIFT: begin
        if (!bus.latch)              state_d = IDLE;
        else if (bit_count == FULL)  state_d = OVER;
      end
      OVER:  if (!bus.latch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    shift_en  = bus.latch;
    clr       = !bus.latch;
    commit_ok = !bus.latch && (state_q == SHIFT) && (bit_count == FULL);
    reject    = !bus.latch && (((state_q == SHIFT) && (bit_count != FULL)) ||
                               (state_q == OVER));
  end

  // Registered outputs; busy is taken from the next state so it tracks
  // state_q without a decode after the flop.
  always_comb begin
    led_out_d   = commit_ok ? shift_data : led_out_q;
    out_valid_d = commit_ok;
    frame_err_d = reject;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out_q   <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      led_out_q   <= led_out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.led_out   = led_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

`ifdef LED_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (reject && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_led_serial_rx.sv
// Bench for led_serial_rx: table of frames (word, bit count, expected
// pulses and led_out) plus hand-written idle-latch and mid-frame reset
// sequences.
module tb_led_serial_rx;

  logic clk;
  logic rst_n;

  led_serial_rx_if #(.WIDTH(16)) bus ();

  led_serial_rx #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_errs = 0;

  typedef struct {
    logic [15:0] word;
    int unsigned nbits;
    logic        exp_valid;
    logic        exp_err;
    logic [15:0] exp_led;
  } frame_t;

  frame_t frames[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge; return with outputs of that cycle visible.
  task automatic tick(input logic s, input logic l);
    @(negedge clk);
    bus.serial_in = s;
    bus.latch     = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_err_count();
`ifdef LED_RX_ERR_CNT_EN
    check("err_count", 32'(bus.err_count), exp_errs);
`endif
  endtask

  initial begin
    frames[0] = '{16'hAAAA, 16, 1'b1, 1'b0, 16'hAAAA};
    frames[1] = '{16'h1234, 16, 1'b1, 1'b0, 16'h1234};
    frames[2] = '{16'hBEEF, 16, 1'b1, 1'b0, 16'hBEEF};
    frames[3] = '{16'h00FF, 16, 1'b1, 1'b0, 16'h00FF};
    frames[4] = '{16'h1357, 15, 1'b0, 1'b1, 16'h00FF};
    frames[5] = '{16'hF0F0, 20, 1'b0, 1'b1, 16'h00FF};
    frames[6] = '{16'h0000,  0, 1'b0, 1'b0, 16'h00FF};
    frames[7] = '{16'h8001, 17, 1'b0, 1'b1, 16'h00FF};
    frames[8] = '{16'hFFFF,  1, 1'b0, 1'b1, 16'h00FF};
    frames[9] = '{16'h5A5A, 16, 1'b1, 1'b0, 16'h5A5A};

    rst_n         = 1'b0;
    bus.serial_in = 1'b0;
    bus.latch     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    check("reset led_out",   32'(bus.led_out),   0);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset frame_err", 32'(bus.frame_err), 0);
    check("reset busy",      32'(bus.busy),      0);
    check_err_count();

    // Frames run back-to-back: the first bit follows the commit cycle directly.
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < int'(frames[f].nbits); k++) begin
        logic b;
        b = (k < 16) ? frames[f].word[15-k] : 1'b1;
        tick(b, 1'b1);
        check($sformatf("f%0d bit%0d busy", f, k), 32'(bus.busy), 1);
        check($sformatf("f%0d bit%0d no pulse", f, k),
              32'({bus.out_valid, bus.frame_err}), 0);
      end
      tick(1'b0, 1'b0);
      if (frames[f].exp_err) exp_errs++;
      check($sformatf("f%0d out_valid", f), 32'(bus.out_valid), 32'(frames[f].exp_valid));
      check($sformatf("f%0d frame_err", f), 32'(bus.frame_err), 32'(frames[f].exp_err));
      check($sformatf("f%0d led_out", f),   32'(bus.led_out),   32'(frames[f].exp_led));
      check($sformatf("f%0d busy", f),      32'(bus.busy),      0);
      check_err_count();
    end

    // Latch held low with serial_in toggling: nothing happens.
    for (int i = 0; i < 5; i++) begin
      tick(i[0], 1'b0);
      check($sformatf("idle%0d pulses", i), 32'({bus.out_valid, bus.frame_err}), 0);
      check($sformatf("idle%0d busy", i),   32'(bus.busy), 0);
      check($sformatf("idle%0d led_out", i), 32'(bus.led_out), 32'h5A5A);
    end
    check_err_count();

    // Reset after 8 bits of a frame: immediate clear, then a clean frame.
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b1);
    check("pre-reset busy", 32'(bus.busy), 1);
    @(negedge clk);
    rst_n     = 1'b0;
    bus.latch = 1'b0;
    #1;
    check("midreset led_out",   32'(bus.led_out),   0);
    check("midreset busy",      32'(bus.busy),      0);
    check("midreset out_valid", 32'(bus.out_valid), 0);
    exp_errs = 0;
    check_err_count();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    check("post-reset out_valid", 32'(bus.out_valid), 1);
    check("post-reset led_out",   32'(bus.led_out),   32'hFFFF);
    check("post-reset frame_err", 32'(bus.frame_err), 0);
    tick(1'b0, 1'b0);
    check("pulse width", 32'(bus.out_valid), 0);
    check_err_count();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_serial_rx.md
# led_serial_rx

Receives the one-bit serial LED stream and its active-low latch strobe produced by the LED serializer and rebuilds the parallel LED word. It sits directly downstream of the serializer, on the same clock, and drives the physical LED bank with a validated, glitch-free parallel pattern. Malformed frames (wrong bit count) are rejected so the displayed pattern never shows a partial or shifted word.

## Interface
- WIDTH, 16, frame length in bits and width of the parallel output
- clk  input  1  system clock; all sampling on rising edge
- rst_n  input  1  asynchronous, active-low reset
- serial_in  input  1  serial data bit, sampled every cycle latch is high
- latch  input  1  active-low commit strobe; a low sample ends the current frame
- led_out  output  WIDTH  last accepted pattern, held between frames
- out_valid  output  1  one-cycle pulse when led_out is updated
- frame_err  output  1  one-cycle pulse when a frame is rejected
- busy  output  1  high while a frame is partially received
- err_count  output  8  rejected-frame count (only with LED_RX_ERR_CNT_EN)

## Operation
- Reset (rst_n low, asynchronous): state IDLE, bit count 0, shift register 0, led_out 0, out_valid 0, frame_err 0, busy 0, err_count 0.
- States: IDLE (no bits held), SHIFT (1..WIDTH bits held), OVER (more than WIDTH bits seen).
- latch high: serial_in shifts in MSB-first; after WIDTH bits, the first bit received sits at led_out[WIDTH-1], the last at led_out[0]. IDLE->SHIFT on first bit; SHIFT->OVER on bit WIDTH+1; OVER absorbs further bits without changing the shift register.
- latch low in SHIFT with count == WIDTH: led_out <= shift register, out_valid pulses, -> IDLE.
- latch low in SHIFT with count != WIDTH, or in OVER: led_out unchanged, frame_err pulses, err_count increments, -> IDLE.
- latch low in IDLE (zero-bit commit, including latch held low for several cycles): ignored; no pulse, no error.
- serial_in is ignored in any cycle where latch is low.
- Count register is sized to hold WIDTH+1 and saturates in OVER; no wrap-around.
- busy = (state != IDLE).

## Timing
- All outputs registered. led_out and out_valid change on the rising edge at which latch is sampled low; visible one cycle later relative to that sample.
- out_valid and frame_err are never high together and are each exactly one cycle wide.
- Back-to-back frames supported: a bit sampled on the cycle right after the commit cycle is bit 1 of the next frame.
- Reset asserted mid-frame discards partial data immediately; led_out returns to 0 with no out_valid.

## Configuration
- LED_RX_ERR_CNT_EN defined: err_count port present, 8-bit, increments on each frame_err, saturates at 255, cleared only by reset.
- Not defined: err_count port and counter absent; frame_err behaviour unchanged.

## Structure
- Shared package led_pkg: state enum (IDLE, SHIFT, OVER), default LED width constant (16), error-counter width constant (8).
- One sub-module: led_rx_shifter (shift register plus saturating bit counter, with shift-enable and clear inputs); FSM, output registers and error counter stay in led_serial_rx.

## Test plan
- Reset then 16 bits 1,0,1,0,... with latch high, latch low one cycle -> led_out = 16'hAAAA, out_valid one pulse, frame_err 0.
- 16 bits of 16'h1234 MSB-first then immediately 16 bits of 16'hBEEF, one latch-low cycle after each -> led_out 16'h1234 then 16'hBEEF, two out_valid pulses.
- Accept 16'h00FF, then send 15 bits and latch low -> frame_err pulse, led_out stays 16'h00FF, err_count = 1.
- Send 20 bits then latch low -> frame_err, busy high from bit 1 until commit, led_out unchanged.
- Latch held low 5 cycles with no bits -> no pulses, busy 0; toggle serial_in while latch low -> no effect.
- Assert rst_n low after 8 bits of a frame -> led_out 0, busy 0 immediately; next full 16'hFFFF frame accepted normally.
